// File: rtl/spi_host_state_pkg.sv
// Shared SPI definitions: host/peripheral state encoding, protocol bytes and
// small byte-formatting helpers.
package spi_host_state_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_POLL  = 3'd4,
    ST_RDATA = 3'd5,
    ST_DONE  = 3'd6
  } spi_state_e;

  localparam logic [7:0]  ACK_BYTE     = 8'h55;
  localparam logic [7:0]  POLL_BYTE    = 8'h00;
  localparam int unsigned CMD_W_BIT    = 7;
  localparam logic [7:0]  CMD_NULL_SUB = 8'h0F;

  // An all-zero command byte is indistinguishable from idle bus traffic,
  // so a read with no byte lanes is sent as 0x0F instead.
  function automatic logic [7:0] cmd_byte(input logic we, input logic [3:0] sel);
    logic [7:0] b;
    b            = '0;
    b[CMD_W_BIT] = we;
    b[3:0]       = sel;
    return (b == '0) ? CMD_NULL_SUB : b;
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_host_state.sv
// Wishbone responder that turns one register access into an SPI byte
// transaction (command, address, data, busy-poll) with one byte in flight.
module spi_host_state
  import spi_host_state_pkg::*;
#(
  parameter int unsigned POLL_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [7:0]  wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        spi_cs_n,
  output logic [7:0]  spi_tx_data,
  output logic        spi_tx_stb,
  input  logic [7:0]  spi_rx_data,
  input  logic        spi_rx_stb
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(POLL_MAX);

  spi_state_e    state_q, state_d;
  logic          pend_q, pend_d;
  logic          we_q, we_d;
  logic [7:0]    adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          err_q, err_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   dat_o_q, dat_o_d;
  logic          tx_stb_q, tx_stb_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          rx_ok;

  assign rx_ok = spi_rx_stb & pend_q;

  // Each response both retires the outstanding byte and, in the same edge,
  // issues the next one, so pend_q is only low in IDLE and DONE.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    err_d     = err_q;
    bcnt_d    = bcnt_q;
    pcnt_d    = pcnt_q;
    rdata_d   = rdata_q;
    dat_o_d   = dat_o_q;
    tx_stb_d  = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: if (wb_stb) begin
        we_d      = wb_we;
        adr_d     = wb_adr;
        dat_d     = wb_dat_i;
        err_d     = 1'b0;
        state_d   = ST_CMD;
        tx_stb_d  = 1'b1;
        tx_data_d = cmd_byte(wb_we, wb_sel);
      end
      ST_CMD: if (rx_ok) begin
        state_d   = ST_ADDR;
        tx_stb_d  = 1'b1;
        tx_data_d = adr_q;
      end
      ST_ADDR: if (rx_ok) begin
        tx_stb_d = 1'b1;
        if (we_q) begin
          state_d   = ST_WDATA;
          tx_data_d = word_byte(dat_q, 2'd0);
        end else begin
          state_d   = ST_POLL;
          tx_data_d = POLL_BYTE;
          pcnt_d    = PW'(1);
        end
      end
      ST_WDATA: if (rx_ok) begin
        tx_stb_d = 1'b1;
        bcnt_d   = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          state_d   = ST_POLL;
          tx_data_d = POLL_BYTE;
          pcnt_d    = PW'(1);
        end else begin
          tx_data_d = word_byte(dat_q, bcnt_q + 2'd1);
        end
      end
      ST_POLL: if (rx_ok) begin
        if (spi_rx_data == ACK_BYTE) begin
          pcnt_d = '0;
          if (we_q) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RDATA;
            tx_stb_d  = 1'b1;
            tx_data_d = POLL_BYTE;
          end
        end else if (pcnt_q == PCNT_MAX) begin
          pcnt_d  = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          pcnt_d    = pcnt_q + PW'(1);
          tx_stb_d  = 1'b1;
          tx_data_d = POLL_BYTE;
        end
      end
      ST_RDATA: if (rx_ok) begin
        rdata_d = {rdata_q[23:0], spi_rx_data};
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          dat_o_d = {rdata_q[23:0], spi_rx_data};
          state_d = ST_DONE;
        end else begin
          tx_stb_d  = 1'b1;
          tx_data_d = POLL_BYTE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (tx_stb_d)   pend_d = 1'b1;
    else if (rx_ok) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      err_q     <= 1'b0;
      bcnt_q    <= '0;
      pcnt_q    <= '0;
      rdata_q   <= '0;
      dat_o_q   <= '0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      err_q     <= err_d;
      bcnt_q    <= bcnt_d;
      pcnt_q    <= pcnt_d;
      rdata_q   <= rdata_d;
      dat_o_q   <= dat_o_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign wb_stall    = (state_q != ST_IDLE) | ~rst_n;
  assign wb_ack      = (state_q == ST_DONE) & ~err_q;
  assign wb_err      = (state_q == ST_DONE) & err_q;
  assign spi_cs_n    = (state_q == ST_IDLE) | (state_q == ST_DONE);
  assign wb_dat_o    = dat_o_q;
  assign spi_tx_data = tx_data_q;
  assign spi_tx_stb  = tx_stb_q;

endmodule

// File: tb/tb_spi_host_state.sv
// Bench for spi_host_state: an SPI peripheral model answers each strobed
// byte after a random delay; each transaction is checked against an
// independently built expected byte list and outcome.
module tb_spi_host_state;

  localparam int PMAX = 4;

  logic        clk;
  logic        rst_n;
  logic        wb_stb, wb_we;
  logic [7:0]  wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_stall, wb_ack, wb_err, spi_cs_n;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_stb;
  logic [7:0]  rx_data;
  logic        rx_stb_r, spur_stb;
  logic        spi_rx_stb;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] tx_log[$];
  logic [7:0] rsp_q[$];

  assign spi_rx_stb = rx_stb_r | spur_stb;

  spi_host_state #(.POLL_MAX(PMAX)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_adr     (wb_adr),
    .wb_sel     (wb_sel),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_stall   (wb_stall),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .spi_cs_n   (spi_cs_n),
    .spi_tx_data(spi_tx_data),
    .spi_tx_stb (spi_tx_stb),
    .spi_rx_data(rx_data),
    .spi_rx_stb (spi_rx_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral model: log every strobed byte, reply after 0..2 cycles.
  initial begin : responder
    int d;
    logic [7:0] r;
    rx_stb_r = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      rx_stb_r = 1'b0;
      if (spi_tx_stb === 1'b1) begin
        tx_log.push_back(spi_tx_data);
        if (rsp_q.size() > 0) r = rsp_q.pop_front();
        else r = 8'hA5;
        d = int'($urandom_range(0, 2));
        repeat (d) begin
          @(posedge clk);
          #1;
        end
        rx_data  = r;
        rx_stb_r = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic run_txn(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int npre, input logic [31:0] rdw,
                         input bit hold, input string nm);
    logic [7:0]  exp_tx[$];
    logic [7:0]  cmd, r;
    bit          exp_err, done, busy_ok, seq_ok;
    int          polls, cyc, bad_idx;
    logic        got_ack, got_err, got_cs;
    logic [31:0] got_dat;
    exp_tx.delete();
    rsp_q.delete();
    tx_log.delete();
    cmd = {we, 3'b000, sel};
    if (cmd == 8'h00) cmd = 8'h0F;
    exp_tx.push_back(cmd);
    rsp_q.push_back(8'($urandom));
    exp_tx.push_back(adr);
    rsp_q.push_back(8'($urandom));
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        exp_tx.push_back(dat[31-8*i -: 8]);
        rsp_q.push_back(8'($urandom));
      end
    end
    exp_err = (npre >= PMAX);
    polls   = exp_err ? PMAX : npre + 1;
    for (int i = 0; i < polls; i++) begin
      exp_tx.push_back(8'h00);
      if (i < npre) begin
        r = 8'($urandom);
        if (r == 8'h55) r = 8'h54;
        rsp_q.push_back(r);
      end else begin
        rsp_q.push_back(8'h55);
      end
    end
    if (!we && !exp_err) begin
      for (int i = 0; i < 4; i++) begin
        exp_tx.push_back(8'h00);
        rsp_q.push_back(rdw[31-8*i -: 8]);
      end
    end

    @(negedge clk);
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_adr   = adr;
    wb_sel   = sel;
    wb_dat_i = dat;
    #1;
    n_vec++;
    if (wb_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: wb_stall=%b, required 0", nm, wb_stall);
    end
    @(posedge clk);
    #1;
    if (hold) begin
      wb_we    = ~we;
      wb_adr   = ~adr;
      wb_sel   = ~sel;
      wb_dat_i = ~dat;
    end else begin
      wb_stb = 1'b0;
    end

    cyc = 0; done = 1'b0; busy_ok = 1'b1;
    while (!done && cyc < 400) begin
      if (wb_ack === 1'b1 || wb_err === 1'b1) begin
        done = 1'b1;
      end else begin
        if (spi_cs_n !== 1'b0 || wb_stall !== 1'b1) busy_ok = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    got_ack = wb_ack; got_err = wb_err; got_cs = spi_cs_n; got_dat = wb_dat_o;
    if (hold) begin
      @(negedge clk);
      wb_stb = 1'b0;
    end

    n_vec++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s timeout: no ack/err in %0d cycles, required one", nm, cyc);
    end
    n_vec++;
    if ({got_ack, got_err} !== {~exp_err, exp_err}) begin
      n_bad++;
      $display("FAIL %s outcome: ack/err=%b%b, required %b%b", nm, got_ack, got_err, ~exp_err, exp_err);
    end
    n_vec++;
    if (got_cs !== 1'b1) begin
      n_bad++;
      $display("FAIL %s cs_end: spi_cs_n=%b at ack/err, required 1", nm, got_cs);
    end
    n_vec++;
    if (busy_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy: cs_n low & stall high not held while busy, got %b required 1", nm, busy_ok);
    end
    if (!we && !exp_err) begin
      n_vec++;
      if (got_dat !== rdw) begin
        n_bad++;
        $display("FAIL %s rdata: wb_dat_o=%h, required %h", nm, got_dat, rdw);
      end
    end

    @(posedge clk);
    #1;
    n_vec++;
    if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s pulse: ack/err=%b%b a cycle later, required 00", nm, wb_ack, wb_err);
    end
    repeat (5) @(posedge clk);
    #1;
    seq_ok = (tx_log.size() == exp_tx.size());
    bad_idx = -1;
    if (seq_ok) begin
      for (int i = 0; i < exp_tx.size(); i++) begin
        if (tx_log[i] !== exp_tx[i] && bad_idx < 0) bad_idx = i;
      end
    end
    n_vec++;
    if (!seq_ok || bad_idx >= 0) begin
      n_bad++;
      if (!seq_ok)
        $display("FAIL %s txseq: %0d bytes sent, required %0d", nm, tx_log.size(), exp_tx.size());
      else
        $display("FAIL %s txseq: byte %0d = %h, required %h", nm, bad_idx, tx_log[bad_idx], exp_tx[bad_idx]);
    end
    if (!we && !exp_err) begin
      n_vec++;
      if (wb_dat_o !== rdw) begin
        n_bad++;
        $display("FAIL %s rdhold: wb_dat_o=%h after ack, required %h", nm, wb_dat_o, rdw);
      end
    end
  endtask

  task automatic test_reset;
    wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_sel = '0; wb_dat_i = '0;
    spur_stb = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({wb_stall, spi_cs_n, spi_tx_stb, wb_ack, wb_err, spi_tx_data, wb_dat_o} !== {5'b11000, 8'h00, 32'h0}) begin
      n_bad++;
      $display("FAIL reset: stall/cs/txstb/ack/err/txd/dat=%b%b%b%b%b %h %h, required 11000 00 00000000",
               wb_stall, spi_cs_n, spi_tx_stb, wb_ack, wb_err, spi_tx_data, wb_dat_o);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (wb_stall !== 1'b1 || spi_cs_n !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hold: stall/cs=%b%b during reset, required 11", wb_stall, spi_cs_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (wb_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: wb_stall=%b, required 0", wb_stall);
    end
  endtask

  task automatic test_directed;
    run_txn(1'b1, 8'h12, 4'hF, 32'hDEADBEEF, 0, 32'h0, 1'b0, "wr_deadbeef");
    run_txn(1'b0, 8'h34, 4'h3, 32'h0, 2, 32'h01020304, 1'b0, "rd_0x34");
    run_txn(1'b0, 8'h77, 4'h0, 32'h0, 0, 32'hCAFEF00D, 1'b0, "rd_sel0");
  endtask

  task automatic test_poll_limit;
    run_txn(1'b0, 8'h40, 4'hC, 32'h0, 1000, 32'h0, 1'b0, "poll_timeout_rd");
    run_txn(1'b1, 8'h41, 4'h1, 32'h01234567, PMAX, 32'h0, 1'b0, "poll_timeout_wr");
    run_txn(1'b0, 8'h42, 4'h5, 32'h0, PMAX - 1, 32'h89ABCDEF, 1'b0, "poll_last_ok");
  endtask

  task automatic test_random;
    for (int k = 0; k < 12; k++) begin
      run_txn(1'($urandom), 8'($urandom), 4'($urandom), $urandom, int'($urandom_range(0, 5)),
              $urandom, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back;
    tx_log.delete();
    @(negedge clk);
    spur_stb = 1'b1;
    @(negedge clk);
    spur_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (tx_log.size() != 0 || wb_ack !== 1'b0 || wb_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL spurious_idle: %0d bytes, ack=%b, stall=%b, required 0 bytes, 0, 0",
               tx_log.size(), wb_ack, wb_stall);
    end
    run_txn(1'b0, 8'h9C, 4'h6, 32'h0, 1, 32'h5A5AA5A5, 1'b1, "hold_rd");
    run_txn(1'b1, 8'h3E, 4'h9, 32'hF00DFACE, 2, 32'h0, 1'b1, "hold_wr");
  endtask

  task automatic test_reset_mid;
    int  cyc;
    bit  saw;
    rsp_q.delete();
    tx_log.delete();
    @(negedge clk);
    wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 8'h5A; wb_sel = 4'hF; wb_dat_i = 32'h11223344;
    @(posedge clk);
    #1;
    wb_stb = 1'b0;
    cyc = 0;
    while (tx_log.size() < 4 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_vec++;
    if (tx_log.size() < 4) begin
      n_bad++;
      $display("FAIL midrst_reach: %0d bytes sent, required 4", tx_log.size());
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({wb_stall, spi_cs_n, spi_tx_stb, wb_ack, wb_err, spi_tx_data, wb_dat_o} !== {5'b11000, 8'h00, 32'h0}) begin
      n_bad++;
      $display("FAIL midrst_async: stall/cs/txstb/ack/err/txd/dat=%b%b%b%b%b %h %h, required 11000 00 00000000",
               wb_stall, spi_cs_n, spi_tx_stb, wb_ack, wb_err, spi_tx_data, wb_dat_o);
    end
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (wb_ack !== 1'b0 || wb_err !== 1'b0) saw = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (wb_ack !== 1'b0 || wb_err !== 1'b0) saw = 1'b1;
    end
    n_vec++;
    if (saw !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_noack: ack/err pulse seen=%b, required 0", saw);
    end
    run_txn(1'b1, 8'h5A, 4'hF, 32'h11223344, 0, 32'h0, 1'b0, "after_reset_wr");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_poll_limit();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
